// File: rtl/mem_burst_arbiter_if.sv
// Requester-side and memory-side burst signals around mem_burst_arbiter.
// master = arbiter side; slave = the frame-buffer requesters plus the memory controller.
interface mem_burst_arbiter_if #(
   parameter int MEM_DATA_BITS = 64,
   parameter int ADDR_BITS     = 24
);
   // Handshake: a *_burst_req is a level held until the arbiter has latched it;
   // every cycle a *_data_req / *_data_valid strobe is high moves exactly one word
   // (no back-pressure); *_finish is a one-cycle pulse that closes the burst.
   logic [1:0]                          wr_burst_req;
   logic [1:0][9:0]                     wr_burst_len;
   logic [1:0][ADDR_BITS-1:0]           wr_burst_addr;
   logic [1:0][MEM_DATA_BITS-1:0]       wr_burst_data;
   logic [1:0]                          wr_burst_data_req;
   logic [1:0]                          wr_burst_finish;

   logic [1:0]                          rd_burst_req;
   logic [1:0][9:0]                     rd_burst_len;
   logic [1:0][ADDR_BITS-1:0]           rd_burst_addr;
   logic [1:0]                          rd_burst_data_valid;
   logic [MEM_DATA_BITS-1:0]            rd_burst_data;
   logic [1:0]                          rd_burst_finish;

   logic                                mem_wr_burst_req;
   logic                                mem_rd_burst_req;
   logic [9:0]                          mem_burst_len;
   logic [ADDR_BITS-1:0]                mem_burst_addr;
   logic                                mem_wr_burst_data_req;
   logic [MEM_DATA_BITS-1:0]            mem_wr_burst_data;
   logic                                mem_rd_burst_data_valid;
   logic [MEM_DATA_BITS-1:0]            mem_rd_burst_data;
   logic                                mem_burst_finish;

   logic [2:0]                          grant;
   logic [1:0]                          dbg_state;
   logic [1:0]                          dbg_rr_ptr;

   modport master (
      input  wr_burst_req, wr_burst_len, wr_burst_addr, wr_burst_data,
      output wr_burst_data_req, wr_burst_finish,
      input  rd_burst_req, rd_burst_len, rd_burst_addr,
      output rd_burst_data_valid, rd_burst_data, rd_burst_finish,
      output mem_wr_burst_req, mem_rd_burst_req, mem_burst_len, mem_burst_addr,
      input  mem_wr_burst_data_req,
      output mem_wr_burst_data,
      input  mem_rd_burst_data_valid, mem_rd_burst_data, mem_burst_finish,
      output grant, dbg_state, dbg_rr_ptr
   );

   modport slave (
      output wr_burst_req, wr_burst_len, wr_burst_addr, wr_burst_data,
      input  wr_burst_data_req, wr_burst_finish,
      output rd_burst_req, rd_burst_len, rd_burst_addr,
      input  rd_burst_data_valid, rd_burst_data, rd_burst_finish,
      input  mem_wr_burst_req, mem_rd_burst_req, mem_burst_len, mem_burst_addr,
      output mem_wr_burst_data_req,
      input  mem_wr_burst_data,
      output mem_rd_burst_data_valid, mem_rd_burst_data, mem_burst_finish,
      input  grant, dbg_state, dbg_rr_ptr
   );
endinterface

// File: rtl/mem_burst_arbiter.sv
// Four-channel round-robin arbiter sharing one DDR2 burst port between two
// frame-buffer writers (ch 0-1) and two readers (ch 2-3), one burst at a time.
module mem_burst_arbiter #(
   parameter int MEM_DATA_BITS = 64,
   parameter int ADDR_BITS     = 24
) (
   input  logic                mem_clk,
   input  logic                rst_n,
   mem_burst_arbiter_if.master bus
);
   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] ISSUE = 2'd1;
   localparam logic [1:0] BUSY  = 2'd2;
   localparam logic [1:0] DONE  = 2'd3;

   logic [1:0]           state_q, state_d;
   logic [1:0]           ch_q, ch_d;
   logic [1:0]           rr_ptr_q, rr_ptr_d;
   logic [ADDR_BITS-1:0] addr_q, addr_d;
   logic [9:0]           len_q, len_d;
   logic                 mem_wr_req_q, mem_wr_req_d;
   logic                 mem_rd_req_q, mem_rd_req_d;
   logic [3:0]           fin_q, fin_d;

   logic [3:0]           req_vec;
   logic                 pick_valid;
   logic [1:0]           pick_ch;
   logic [1:0]           idx;
   logic                 busy;

   logic [1:0]               wr_dreq;
   logic [1:0]               rd_dvalid;
   logic [MEM_DATA_BITS-1:0] wr_word;

   assign req_vec = {bus.rd_burst_req, bus.wr_burst_req};

   // Cyclic search starting at rr_ptr; the 2-bit index wraps 3 -> 0 naturally.
   always_comb begin
      pick_valid = 1'b0;
      pick_ch    = rr_ptr_q;
      idx        = rr_ptr_q;
      for (int i = 0; i < 4; i++) begin
         idx = rr_ptr_q + 2'(i);
         if (!pick_valid && req_vec[idx]) begin
            pick_valid = 1'b1;
            pick_ch    = idx;
         end
      end
   end

   always_comb begin
      state_d      = state_q;
      ch_d         = ch_q;
      rr_ptr_d     = rr_ptr_q;
      addr_d       = addr_q;
      len_d        = len_q;
      mem_wr_req_d = mem_wr_req_q;
      mem_rd_req_d = mem_rd_req_q;
      fin_d        = '0;
      case (state_q)
         IDLE: begin
            if (pick_valid) begin
               ch_d = pick_ch;
               if (pick_ch[1]) begin
                  addr_d = bus.rd_burst_addr[pick_ch[0]];
                  len_d  = bus.rd_burst_len[pick_ch[0]];
               end else begin
                  addr_d = bus.wr_burst_addr[pick_ch[0]];
                  len_d  = bus.wr_burst_len[pick_ch[0]];
               end
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            if (len_q == 10'd0) begin
               fin_d[ch_q] = 1'b1;
               state_d     = DONE;
            end else begin
               mem_wr_req_d = ~ch_q[1];
               mem_rd_req_d = ch_q[1];
               state_d      = BUSY;
            end
         end
         BUSY: begin
            // The memory controller has accepted the burst once it moves a word or finishes.
            if (bus.mem_wr_burst_data_req || bus.mem_rd_burst_data_valid || bus.mem_burst_finish) begin
               mem_wr_req_d = 1'b0;
               mem_rd_req_d = 1'b0;
            end
            if (bus.mem_burst_finish) begin
               fin_d[ch_q] = 1'b1;
               state_d     = DONE;
            end
         end
         DONE: begin
            rr_ptr_d = ch_q + 2'd1;
            state_d  = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge mem_clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         ch_q         <= 2'd0;
         rr_ptr_q     <= 2'd0;
         addr_q       <= '0;
         len_q        <= 10'd0;
         mem_wr_req_q <= 1'b0;
         mem_rd_req_q <= 1'b0;
         fin_q        <= 4'd0;
      end else begin
         state_q      <= state_d;
         ch_q         <= ch_d;
         rr_ptr_q     <= rr_ptr_d;
         addr_q       <= addr_d;
         len_q        <= len_d;
         mem_wr_req_q <= mem_wr_req_d;
         mem_rd_req_q <= mem_rd_req_d;
         fin_q        <= fin_d;
      end
   end

   assign busy = (state_q != IDLE);

   // Strobes follow the grant register only; anything arriving while idle goes nowhere.
   always_comb begin
      wr_dreq   = 2'b00;
      rd_dvalid = 2'b00;
      wr_word   = '0;
      if (busy && !ch_q[1]) begin
         wr_dreq[ch_q[0]] = bus.mem_wr_burst_data_req;
         wr_word          = bus.wr_burst_data[ch_q[0]];
      end
      if (busy && ch_q[1]) begin
         rd_dvalid[ch_q[0]] = bus.mem_rd_burst_data_valid;
      end
   end

   assign bus.wr_burst_data_req   = wr_dreq;
   assign bus.rd_burst_data_valid = rd_dvalid;
   assign bus.mem_wr_burst_data   = wr_word;
   assign bus.rd_burst_data       = bus.mem_rd_burst_data;
   assign bus.wr_burst_finish     = fin_q[1:0];
   assign bus.rd_burst_finish     = fin_q[3:2];
   assign bus.mem_wr_burst_req    = mem_wr_req_q;
   assign bus.mem_rd_burst_req    = mem_rd_req_q;
   assign bus.mem_burst_len       = len_q;
   assign bus.mem_burst_addr      = addr_q;
   assign bus.grant               = {busy, ch_q};
   assign bus.dbg_state           = state_q;
   assign bus.dbg_rr_ptr          = rr_ptr_q;
endmodule

// File: tb/tb_mem_burst_arbiter.sv
// Randomized bench for mem_burst_arbiter: memory-side responder tasks, event monitors
// and a round-robin reference model that predicts every grant from the request set.
`timescale 1ns/1ps
module tb_mem_burst_arbiter;
   localparam int MDB = 64;
   localparam int AB  = 24;

   logic mem_clk = 1'b0;
   logic rst_n   = 1'b0;
   always #5 mem_clk = ~mem_clk;

   mem_burst_arbiter_if #(.MEM_DATA_BITS(MDB), .ADDR_BITS(AB)) bus ();

   mem_burst_arbiter #(.MEM_DATA_BITS(MDB), .ADDR_BITS(AB)) dut (
      .mem_clk (mem_clk),
      .rst_n   (rst_n),
      .bus     (bus)
   );

   int n_vec = 0;
   int n_err = 0;
   int cyc   = 0;

   int fin_cnt[4]  = '{0, 0, 0, 0};
   int fin_cyc[4]  = '{0, 0, 0, 0};
   int wdr_cnt[2]  = '{0, 0};
   int wdr_good[2] = '{0, 0};
   int rdv_cnt[2]  = '{0, 0};
   int rdv_good[2] = '{0, 0};
   int req_cnt     = 0;
   int req_fall_cyc = 0;
   int first_strobe_cyc = 0;
   logic prev_req = 1'b0;

   logic [MDB-1:0] wpat[2];
   logic [MDB-1:0] rd_word = '0;
   logic [AB-1:0]  ch_addr[4];
   int             ch_len[4];
   int             model_ptr = 0;
   logic [1:0]     exp_q[$];

   always @(posedge mem_clk) cyc <= cyc + 1;

   // Event monitor, sampled mid-cycle.
   always @(negedge mem_clk) begin
      logic mreq;
      mreq = bus.mem_wr_burst_req | bus.mem_rd_burst_req;
      if (mreq && !prev_req) req_cnt++;
      if (!mreq && prev_req) req_fall_cyc = cyc;
      prev_req = mreq;
      for (int c = 0; c < 2; c++) begin
         if (bus.wr_burst_finish[c] === 1'b1) begin fin_cnt[c]++; fin_cyc[c] = cyc; end
         if (bus.rd_burst_finish[c] === 1'b1) begin fin_cnt[c+2]++; fin_cyc[c+2] = cyc; end
         if (bus.wr_burst_data_req[c] === 1'b1) begin
            wdr_cnt[c]++;
            if (bus.mem_wr_burst_data === wpat[c]) wdr_good[c]++;
         end
         if (bus.rd_burst_data_valid[c] === 1'b1) begin
            rdv_cnt[c]++;
            if (bus.rd_burst_data === rd_word) rdv_good[c]++;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Reference model: first requesting channel at or after ptr, cyclically.
   function automatic int model_pick(input logic [3:0] reqs, input int ptr);
      for (int i = 0; i < 4; i++) if (reqs[(ptr + i) % 4]) return (ptr + i) % 4;
      return -1;
   endfunction

   function automatic int fin_total();
      return fin_cnt[0] + fin_cnt[1] + fin_cnt[2] + fin_cnt[3];
   endfunction

   function automatic int strobe_total();
      return wdr_cnt[0] + wdr_cnt[1] + rdv_cnt[0] + rdv_cnt[1];
   endfunction

   task automatic step();
      @(posedge mem_clk);
      #1;
   endtask

   task automatic clear_inputs();
      bus.wr_burst_req = 2'b00;
      bus.rd_burst_req = 2'b00;
      bus.wr_burst_len = '0;
      bus.rd_burst_len = '0;
      bus.wr_burst_addr = '0;
      bus.rd_burst_addr = '0;
      bus.wr_burst_data = '0;
      bus.mem_wr_burst_data_req = 1'b0;
      bus.mem_rd_burst_data_valid = 1'b0;
      bus.mem_rd_burst_data = '0;
      bus.mem_burst_finish = 1'b0;
   endtask

   task automatic set_chan(input int c, input bit req, input int len, input logic [AB-1:0] addr);
      ch_addr[c] = addr;
      ch_len[c]  = len;
      if (c < 2) begin
         bus.wr_burst_req[c%2]  = req;
         bus.wr_burst_len[c%2]  = 10'(len);
         bus.wr_burst_addr[c%2] = addr;
         bus.wr_burst_data[c%2] = wpat[c%2];
      end else begin
         bus.rd_burst_req[c%2]  = req;
         bus.rd_burst_len[c%2]  = 10'(len);
         bus.rd_burst_addr[c%2] = addr;
      end
   endtask

   task automatic drop_reqs();
      bus.wr_burst_req = 2'b00;
      bus.rd_burst_req = 2'b00;
   endtask

   task automatic wait_mem_req(output bit ok, output int rise);
      ok = 1'b0;
      rise = -1;
      for (int k = 0; k < 20; k++) begin
         if (bus.mem_wr_burst_req || bus.mem_rd_burst_req) begin
            ok = 1'b1;
            rise = cyc;
            break;
         end
         step();
      end
   endtask

   // Memory-side responder: n word strobes (optional idle gaps) then a finish pulse.
   task automatic mem_serve(input int n, input bit gaps, output int fin_drv);
      bit is_rd;
      is_rd = bus.mem_rd_burst_req;
      for (int k = 0; k < n; k++) begin
         if (gaps && $urandom_range(0, 3) == 0) step();
         if (is_rd) begin
            rd_word = {$urandom, $urandom};
            bus.mem_rd_burst_data = rd_word;
            bus.mem_rd_burst_data_valid = 1'b1;
         end else begin
            bus.mem_wr_burst_data_req = 1'b1;
         end
         if (k == 0) first_strobe_cyc = cyc;
         step();
         bus.mem_rd_burst_data_valid = 1'b0;
         bus.mem_wr_burst_data_req = 1'b0;
      end
      bus.mem_burst_finish = 1'b1;
      fin_drv = cyc;
      step();
      bus.mem_burst_finish = 1'b0;
   endtask

   task automatic test_reset();
      logic [AB+10+2+3+8-1:0] outs;
      clear_inputs();
      wpat[0] = {$urandom, $urandom};
      wpat[1] = {$urandom, $urandom};
      repeat (3) step();
      outs = {bus.mem_wr_burst_req, bus.mem_rd_burst_req, bus.mem_burst_len, bus.mem_burst_addr,
              bus.grant, bus.wr_burst_finish, bus.rd_burst_finish, bus.wr_burst_data_req,
              bus.rd_burst_data_valid};
      n_vec++;
      if (outs !== '0) begin n_err++; $display("FAIL reset_outputs: got %0h want 0", outs); end
      n_vec++;
      if (bus.mem_wr_burst_data !== '0) begin n_err++; $display("FAIL reset_wdata: got %0h want 0", bus.mem_wr_burst_data); end
      n_vec++;
      if (bus.dbg_rr_ptr !== 2'd0) begin n_err++; $display("FAIL reset_rr_ptr: got %0d want 0", bus.dbg_rr_ptr); end
      rst_n = 1'b1;
      repeat (2) step();
      model_ptr = 0;
   endtask

   task automatic test_single_write();
      bit ok; int rise, drv, fdrv, w0, w1, g0, f0, ft;
      w0 = wdr_cnt[0]; w1 = wdr_cnt[1]; g0 = wdr_good[0]; f0 = fin_cnt[0]; ft = fin_total();
      set_chan(0, 1'b1, 128, 24'h000200);
      drv = cyc;
      step();
      drop_reqs();
      wait_mem_req(ok, rise);
      n_vec++;
      if (!ok) begin n_err++; $display("FAIL wr0_req_timeout: no memory request"); return; end
      n_vec++;
      if (rise - drv !== 2) begin n_err++; $display("FAIL wr0_req_latency: got %0d want 2", rise - drv); end
      n_vec++;
      if ({bus.mem_wr_burst_req, bus.mem_rd_burst_req} !== 2'b10) begin n_err++; $display("FAIL wr0_req_type: got %b want 10", {bus.mem_wr_burst_req, bus.mem_rd_burst_req}); end
      n_vec++;
      if (bus.mem_burst_addr !== 24'h000200 || bus.mem_burst_len !== 10'd128) begin n_err++; $display("FAIL wr0_addr_len: got %h/%0d want 000200/128", bus.mem_burst_addr, bus.mem_burst_len); end
      n_vec++;
      if (bus.grant !== 3'b100) begin n_err++; $display("FAIL wr0_grant: got %b want 100", bus.grant); end
      mem_serve(128, 1'b1, fdrv);
      step();
      n_vec++;
      if (req_fall_cyc !== first_strobe_cyc + 1) begin n_err++; $display("FAIL wr0_req_fall: got cyc %0d want %0d", req_fall_cyc, first_strobe_cyc + 1); end
      n_vec++;
      if (wdr_cnt[0] - w0 !== 128 || wdr_good[0] - g0 !== 128) begin n_err++; $display("FAIL wr0_strobes: got %0d (%0d good) want 128", wdr_cnt[0] - w0, wdr_good[0] - g0); end
      n_vec++;
      if (wdr_cnt[1] - w1 !== 0) begin n_err++; $display("FAIL wr1_stray_strobes: got %0d want 0", wdr_cnt[1] - w1); end
      n_vec++;
      if (fin_cnt[0] - f0 !== 1 || fin_total() - ft !== 1 || fin_cyc[0] !== fdrv + 1) begin n_err++; $display("FAIL wr0_finish: got %0d pulses at cyc %0d want 1 at %0d", fin_cnt[0] - f0, fin_cyc[0], fdrv + 1); end
      step();
      model_ptr = 1;
   endtask

   task automatic test_read();
      bit ok; int rise, fdrv, r0, r1, g1, f3, g;
      logic [AB-1:0] a;
      r0 = rdv_cnt[0]; r1 = rdv_cnt[1]; g1 = rdv_good[1]; f3 = fin_cnt[3];
      a = AB'($urandom);
      g = model_pick(4'b1000, model_ptr);
      set_chan(3, 1'b1, 16, a);
      step();
      drop_reqs();
      wait_mem_req(ok, rise);
      n_vec++;
      if (!ok) begin n_err++; $display("FAIL rd1_req_timeout: no memory request"); return; end
      n_vec++;
      if ({bus.mem_wr_burst_req, bus.mem_rd_burst_req} !== 2'b01 || bus.mem_burst_addr !== a) begin n_err++; $display("FAIL rd1_req: got type %b addr %h want 01 %h", {bus.mem_wr_burst_req, bus.mem_rd_burst_req}, bus.mem_burst_addr, a); end
      n_vec++;
      if (bus.grant !== {1'b1, 2'(g)}) begin n_err++; $display("FAIL rd1_grant: got %b want %b", bus.grant, {1'b1, 2'(g)}); end
      mem_serve(16, 1'b1, fdrv);
      step();
      n_vec++;
      if (rdv_cnt[1] - r1 !== 16 || rdv_good[1] - g1 !== 16) begin n_err++; $display("FAIL rd1_valids: got %0d (%0d good) want 16", rdv_cnt[1] - r1, rdv_good[1] - g1); end
      n_vec++;
      if (rdv_cnt[0] - r0 !== 0) begin n_err++; $display("FAIL rd0_stray_valids: got %0d want 0", rdv_cnt[0] - r0); end
      n_vec++;
      if (fin_cnt[3] - f3 !== 1) begin n_err++; $display("FAIL rd1_finish: got %0d want 1", fin_cnt[3] - f3); end
      step();
      model_ptr = (g + 1) % 4;
   endtask

   task automatic test_zero_len();
      int drv, f1, rq, g;
      f1 = fin_cnt[1]; rq = req_cnt;
      g = model_pick(4'b0010, model_ptr);
      set_chan(1, 1'b1, 0, AB'($urandom));
      drv = cyc;
      step();
      drop_reqs();
      repeat (4) step();
      n_vec++;
      if (fin_cnt[1] - f1 !== 1 || fin_cyc[1] !== drv + 2) begin n_err++; $display("FAIL zero_len_finish: got %0d at cyc %0d want 1 at %0d", fin_cnt[1] - f1, fin_cyc[1], drv + 2); end
      n_vec++;
      if (req_cnt !== rq) begin n_err++; $display("FAIL zero_len_mem_req: got %0d requests want 0", req_cnt - rq); end
      model_ptr = (g + 1) % 4;
      n_vec++;
      if (bus.dbg_rr_ptr !== 2'(model_ptr)) begin n_err++; $display("FAIL zero_len_rr_ptr: got %0d want %0d", bus.dbg_rr_ptr, model_ptr); end
   endtask

   task automatic test_round_robin();
      bit ok; int rise, fdrv, prev_fin, g;
      logic [1:0] e;
      for (int c = 0; c < 4; c++) set_chan(c, 1'b1, 4, AB'($urandom));
      for (int b = 0; b < 8; b++) begin
         g = model_pick(4'hF, model_ptr);
         exp_q.push_back(2'(g));
         model_ptr = (g + 1) % 4;
      end
      prev_fin = 0;
      for (int b = 0; b < 8; b++) begin
         wait_mem_req(ok, rise);
         n_vec++;
         if (!ok) begin n_err++; $display("FAIL rr_req_timeout: burst %0d", b); drop_reqs(); return; end
         e = exp_q.pop_front();
         n_vec++;
         if (bus.grant !== {1'b1, e} || bus.mem_burst_addr !== ch_addr[e]) begin n_err++; $display("FAIL rr_grant: burst %0d got %b addr %h want %b addr %h", b, bus.grant, bus.mem_burst_addr, {1'b1, e}, ch_addr[e]); end
         if (b > 0) begin
            n_vec++;
            if (rise - prev_fin !== 4) begin n_err++; $display("FAIL rr_gap: burst %0d got %0d want 4", b, rise - prev_fin); end
         end
         mem_serve(4, 1'b0, fdrv);
         prev_fin = fdrv;
         if (b == 7) drop_reqs();
      end
      repeat (6) step();
      n_vec++;
      if (bus.mem_wr_burst_req !== 1'b0 || bus.mem_rd_burst_req !== 1'b0 || bus.grant[2] !== 1'b0) begin n_err++; $display("FAIL rr_extra_burst: got grant %b want idle", bus.grant); end
   endtask

   task automatic test_reset_mid_burst();
      bit ok; int rise, fdrv, w0, g;
      logic [AB+10+2+3+8-1:0] outs;
      w0 = wdr_cnt[0];
      set_chan(0, 1'b1, 128, AB'($urandom));
      step();
      drop_reqs();
      wait_mem_req(ok, rise);
      n_vec++;
      if (!ok) begin n_err++; $display("FAIL rst_req_timeout: no memory request"); return; end
      for (int k = 0; k < 50; k++) begin
         bus.mem_wr_burst_data_req = 1'b1;
         step();
         bus.mem_wr_burst_data_req = 1'b0;
      end
      n_vec++;
      if (wdr_cnt[0] - w0 !== 50) begin n_err++; $display("FAIL rst_pre_strobes: got %0d want 50", wdr_cnt[0] - w0); end
      bus.mem_wr_burst_data_req = 1'b1;
      bus.mem_rd_burst_data_valid = 1'b1;
      #2 rst_n = 1'b0;
      #1;
      outs = {bus.mem_wr_burst_req, bus.mem_rd_burst_req, bus.mem_burst_len, bus.mem_burst_addr,
              bus.grant, bus.wr_burst_finish, bus.rd_burst_finish, bus.wr_burst_data_req,
              bus.rd_burst_data_valid};
      n_vec++;
      if (outs !== '0 || bus.mem_wr_burst_data !== '0) begin n_err++; $display("FAIL rst_mid_outputs: got %0h want 0", outs); end
      bus.mem_wr_burst_data_req = 1'b0;
      bus.mem_rd_burst_data_valid = 1'b0;
      repeat (2) step();
      rst_n = 1'b1;
      repeat (2) step();
      model_ptr = 0;
      g = model_pick(4'hF, model_ptr);
      for (int c = 0; c < 4; c++) set_chan(c, 1'b1, 2, AB'($urandom));
      step();
      drop_reqs();
      wait_mem_req(ok, rise);
      n_vec++;
      if (!ok) begin n_err++; $display("FAIL rst_post_timeout: no memory request"); return; end
      n_vec++;
      if (bus.grant !== {1'b1, 2'(g)}) begin n_err++; $display("FAIL rst_post_grant: got %b want %b", bus.grant, {1'b1, 2'(g)}); end
      mem_serve(2, 1'b0, fdrv);
      repeat (2) step();
      model_ptr = (g + 1) % 4;
   endtask

   task automatic test_spurious_finish();
      bit ok; int rise, fdrv, ft, st, rq, g;
      ft = fin_total(); st = strobe_total(); rq = req_cnt;
      bus.mem_burst_finish = 1'b1;
      bus.mem_wr_burst_data_req = 1'b1;
      bus.mem_rd_burst_data_valid = 1'b1;
      repeat (2) step();
      bus.mem_burst_finish = 1'b0;
      bus.mem_wr_burst_data_req = 1'b0;
      bus.mem_rd_burst_data_valid = 1'b0;
      repeat (2) step();
      n_vec++;
      if (fin_total() !== ft || strobe_total() !== st) begin n_err++; $display("FAIL spurious_routed: got %0d finishes %0d strobes want 0", fin_total() - ft, strobe_total() - st); end
      n_vec++;
      if (bus.grant[2] !== 1'b0 || req_cnt !== rq || bus.dbg_rr_ptr !== 2'(model_ptr)) begin n_err++; $display("FAIL spurious_state: got busy %b ptr %0d want 0 %0d", bus.grant[2], bus.dbg_rr_ptr, model_ptr); end
      g = model_pick(4'b0100, model_ptr);
      set_chan(2, 1'b1, 3, AB'($urandom));
      step();
      drop_reqs();
      wait_mem_req(ok, rise);
      n_vec++;
      if (!ok || bus.grant !== {1'b1, 2'(g)}) begin n_err++; $display("FAIL spurious_followup: got ok %0d grant %b want %b", ok, bus.grant, {1'b1, 2'(g)}); end
      if (!ok) return;
      mem_serve(3, 1'b0, fdrv);
      repeat (2) step();
      model_ptr = (g + 1) % 4;
   endtask

   task automatic test_random();
      bit ok; int rise, fdrv, drv, g, ft, fg, st, sg, rq;
      logic [3:0] reqs;
      for (int r = 0; r < 20; r++) begin
         reqs = 4'($urandom_range(1, 15));
         wpat[0] = {$urandom, $urandom};
         wpat[1] = {$urandom, $urandom};
         for (int c = 0; c < 4; c++) set_chan(c, reqs[c], ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 6), AB'($urandom));
         g = model_pick(reqs, model_ptr);
         ft = fin_total(); fg = fin_cnt[g]; st = strobe_total(); rq = req_cnt;
         sg = (g < 2) ? wdr_good[g] : rdv_good[g-2];
         drv = cyc;
         step();
         drop_reqs();
         if (ch_len[g] == 0) begin
            repeat (3) step();
            n_vec++;
            if (fin_cnt[g] - fg !== 1 || fin_cyc[g] !== drv + 2 || req_cnt !== rq) begin n_err++; $display("FAIL rand_zero: round %0d ch %0d got %0d fin at %0d, %0d reqs want 1 at %0d, 0 reqs", r, g, fin_cnt[g] - fg, fin_cyc[g], req_cnt - rq, drv + 2); end
         end else begin
            wait_mem_req(ok, rise);
            n_vec++;
            if (!ok) begin n_err++; $display("FAIL rand_timeout: round %0d", r); return; end
            n_vec++;
            if (bus.grant !== {1'b1, 2'(g)} || bus.mem_burst_addr !== ch_addr[g] || bus.mem_burst_len !== 10'(ch_len[g]) ||
                bus.mem_rd_burst_req !== (g >= 2) || bus.mem_wr_burst_req !== (g < 2)) begin
               n_err++; $display("FAIL rand_issue: round %0d got grant %b addr %h len %0d want %b %h %0d", r, bus.grant, bus.mem_burst_addr, bus.mem_burst_len, {1'b1, 2'(g)}, ch_addr[g], ch_len[g]);
            end
            mem_serve(ch_len[g], 1'b1, fdrv);
            repeat (2) step();
            n_vec++;
            if (fin_cnt[g] - fg !== 1 || fin_total() - ft !== 1) begin n_err++; $display("FAIL rand_finish: round %0d ch %0d got %0d want 1", r, g, fin_cnt[g] - fg); end
            n_vec++;
            if (strobe_total() - st !== ch_len[g] || ((g < 2) ? wdr_good[g] : rdv_good[g-2]) - sg !== ch_len[g]) begin n_err++; $display("FAIL rand_strobes: round %0d ch %0d got %0d want %0d", r, g, strobe_total() - st, ch_len[g]); end
         end
         model_ptr = (g + 1) % 4;
      end
   endtask

   initial begin
      test_reset();
      test_single_write();
      test_read();
      test_zero_len();
      test_round_robin();
      test_reset_mid_burst();
      test_spurious_finish();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/mem_burst_arbiter.md
# mem_burst_arbiter

Four-channel round-robin arbiter that shares the single burst port of the DDR2 memory controller between two write requesters (frame-buffer writers, channels 0–1) and two read requesters (frame-buffer readers, channels 2–3). It latches one requester's address and length, sequences exactly one burst on the memory port, and routes data strobes and completion back to that requester only. It sits between the video frame-buffer controllers and the memory controller, in the `mem_clk` domain.

## Interface
- `MEM_DATA_BITS`, 64, burst data width
- `ADDR_BITS`, 24, burst address width
- `mem_clk`  in  1  memory-side clock; all logic on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `wr_burst_req`  in  2  per write channel: burst request
- `wr_burst_len`  in  2×10  per write channel: burst length in words
- `wr_burst_addr`  in  2×ADDR_BITS  per write channel: start address
- `wr_burst_data`  in  2×MEM_DATA_BITS  per write channel: write data
- `wr_burst_data_req`  out  2  per write channel: data read strobe
- `wr_burst_finish`  out  2  per write channel: burst complete pulse
- `rd_burst_req`  in  2  per read channel: burst request
- `rd_burst_len`  in  2×10  per read channel: burst length
- `rd_burst_addr`  in  2×ADDR_BITS  per read channel: start address
- `rd_burst_data_valid`  out  2  per read channel: read data valid
- `rd_burst_data`  out  MEM_DATA_BITS  read data, shared by both read channels
- `rd_burst_finish`  out  2  per read channel: burst complete pulse
- `mem_wr_burst_req`, `mem_rd_burst_req`  out  1 each  memory-side requests
- `mem_burst_len`  out  10  memory-side length
- `mem_burst_addr`  out  ADDR_BITS  memory-side address
- `mem_wr_burst_data_req`  in  1  memory pulls a write word
- `mem_wr_burst_data`  out  MEM_DATA_BITS  write word to memory
- `mem_rd_burst_data_valid`  in  1  memory presents a read word
- `mem_rd_burst_data`  in  MEM_DATA_BITS  read word from memory
- `mem_burst_finish`  in  1  memory burst complete pulse
- `grant`  out  3  debug: {busy, channel[1:0]}

## Operation
- Channel index: 0 = wr0, 1 = wr1, 2 = rd0, 3 = rd1.
- States: `IDLE`, `ISSUE`, `BUSY`, `DONE`.
- `IDLE`: if any request is high, select the first requesting channel at or after `rr_ptr`, searching cyclically 0→1→2→3→0. Register the channel, its address and its length. Go to `ISSUE`. With no request, stay in `IDLE`.
- `ISSUE`: if the latched length is 0, skip the memory port, pulse the channel's finish, and go to `DONE`. Otherwise assert `mem_wr_burst_req` (channels 0–1) or `mem_rd_burst_req` (channels 2–3), drive `mem_burst_addr` and `mem_burst_len` from the latched values, and go to `BUSY`.
- `BUSY`: keep the memory request high until the first `mem_wr_burst_data_req`, the first `mem_rd_burst_data_valid`, or `mem_burst_finish`, then drop it. Stay in `BUSY` until `mem_burst_finish`, then go to `DONE`.
- `DONE`: set `rr_ptr` to the granted channel + 1 (mod 4) and return to `IDLE`. This cycle lets the requester's registered request fall before re-arbitration.
- Data routing is combinational from the grant register:
  - `wr_burst_data_req[g] = mem_wr_burst_data_req` and `mem_wr_burst_data = wr_burst_data[g]`, only when g is a write channel;
  - `rd_burst_data_valid[g-2] = mem_rd_burst_data_valid`, only when g is a read channel;
  - `rd_burst_data = mem_rd_burst_data`, unconditionally.
- All non-granted strobes and finishes are 0.
- `*_burst_finish[g]` is a registered single-cycle pulse, issued one cycle after `mem_burst_finish` or from the zero-length path.
- A requester that drops its request before grant is not served. Requester inputs are ignored after the latch in `IDLE`.

## Timing
- Reset values:
  - all `mem_*` outputs 0;
  - all `*_data_req`, `*_data_valid` and `*_finish` outputs 0;
  - `grant` = 0, `rr_ptr` = 0, state = `IDLE`.
- Request sampled high in `IDLE` at edge t → memory request high from edge t+2 (`IDLE`→`ISSUE`→`BUSY` registered output).
- `mem_burst_finish` at edge t → requester finish high for cycle t+1 → `IDLE` at t+2. Minimum gap between two memory bursts is 4 cycles.
- `mem_burst_finish` outside `BUSY` is ignored. A strobe from the memory side while `IDLE` is dropped and routed nowhere.
- `rst_n` low mid-burst: everything returns to reset values immediately. The memory controller is expected to be reset by the same `rst_n`.
- Address and length are held constant on the memory port from `ISSUE` through `DONE`.

## Test plan
- Single wr0 request, len 128, addr 0x000200, memory returns 128 data_req and then finish:
  - `mem_wr_burst_req` rises 2 cycles after the request and falls on the first data_req;
  - `wr_burst_data_req[0]` sees exactly 128 pulses, and `wr_burst_data_req[1]` sees none;
  - one `wr_burst_finish[0]` pulse follows.
- All four requests held high continuously, bursts of len 4: grants proceed 0,1,2,3,0,1…, with exactly 4 cycles between each finish and the next memory request.
- Request from rd1 only, len 16:
  - `mem_rd_burst_req` is asserted with the correct address;
  - 16 valids reach `rd_burst_data_valid[1]` carrying the memory data, and `rd_burst_data_valid[0]` stays 0;
  - one `rd_burst_finish[1]` pulse follows.
- wr1 request with len 0:
  - no memory request is ever asserted;
  - `wr_burst_finish[1]` pulses 2 cycles after the request is sampled;
  - `rr_ptr` advances to 2.
- Assert `rst_n` low during `BUSY` after 50 of 128 write words: all outputs are 0 immediately. After release, a new request from wr0 is granted first (`rr_ptr` = 0).
- Spurious `mem_burst_finish` while `IDLE`: no finish pulse on any channel and the state is unchanged.
